// File: rtl/adc_sample_sched.sv
// adc_sample_sched: periodic sampling scheduler for the serial ADC receiver.
// A tick counter fires every P = max(periodo, MIN_PERIOD) clocks. Each tick
// pulses inicio_rx, waits for rx_listo, captures paquete_bits and offers it
// downstream on muestra/muestra_valida.
//
// Handshake: muestra is valid while muestra_valida=1. A transfer happens in
// any cycle with muestra_valida=1 and muestra_lista=1. After a transfer,
// muestra_valida drops on the next cycle unless a new capture lands in that
// same cycle; in that case the new word is loaded and valid stays high.
// muestra_valida does not wait for muestra_lista before rising.
//
// Optional feature macro: ADC_SCHED_TIMEOUT_EN. When it is defined, a silent
// receiver is abandoned after TIMEOUT clocks in RECIBE and timeout_err is
// set. When it is not defined, RECIBE waits forever and timeout_err is 0.
//
// estado_dbg exposes the FSM state register for checkers:
// 0 = ESPERA, 1 = INICIO, 2 = RECIBE.
module adc_sample_sched #(
    parameter int PERIOD_W   = 16,
    parameter int MIN_PERIOD = 20,
    parameter int TIMEOUT    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] periodo,
    input  logic                borrar_flags,
    input  logic                rx_listo,
    input  logic [11:0]         paquete_bits,
    input  logic                muestra_lista,
    output logic                inicio_rx,
    output logic [11:0]         muestra,
    output logic                muestra_valida,
    output logic                ocupado,
    output logic                tick_perdido,
    output logic                overrun,
    output logic                timeout_err,
    output logic [1:0]          estado_dbg
);

    typedef enum logic [1:0] {
        ESPERA = 2'd0,
        INICIO = 2'd1,
        RECIBE = 2'd2
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] per_clamp;
    logic                tick;
    logic                captura;
    logic                tick_perdido_evt;
    logic                overrun_evt;
    logic [11:0]         muestra_q, muestra_d;
    logic                valida_q, valida_d;
    logic                tick_perdido_q, tick_perdido_d;
    logic                overrun_q, overrun_d;

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_evt;
    logic            timeout_err_q, timeout_err_d;
`endif

    // Period clamp and tick decode. The period register is loaded while the
    // counter sits at 0; ticks can never fall on cnt=0 since P >= MIN_PERIOD.
    always_comb begin
        per_clamp = periodo;
        if (periodo < PERIOD_W'(MIN_PERIOD)) begin
            per_clamp = PERIOD_W'(MIN_PERIOD);
        end
        tick = enable && (cnt_q == (per_q - PERIOD_W'(1)));
    end

    // Tick counter: runs 0..P-1 while enabled, parked at 0 otherwise.
    always_comb begin
        cnt_d = cnt_q;
        per_d = per_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
        end
        if (enable && (cnt_q == '0)) begin
            per_d = per_clamp;
        end
    end

    // FSM next state; capture and (optionally) timeout decisions.
    always_comb begin
        estado_d = estado_q;
        captura  = 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        timeout_evt = 1'b0;
`endif
        case (estado_q)
            ESPERA: begin
                if (tick) begin
                    estado_d = INICIO;
                end
            end
            INICIO: begin
                estado_d = RECIBE;
`ifdef ADC_SCHED_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            RECIBE: begin
                if (rx_listo) begin
                    captura  = 1'b1;
                    estado_d = ESPERA;
`ifdef ADC_SCHED_TIMEOUT_EN
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_evt = 1'b1;
                    estado_d    = ESPERA;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            default: begin
                estado_d = ESPERA;
            end
        endcase
    end

    // Output register next values: sample capture, handshake and sticky flags.
    // A flag event in the same cycle as borrar_flags keeps the flag set.
    always_comb begin
        muestra_d        = muestra_q;
        valida_d         = valida_q;
        tick_perdido_evt = tick && (estado_q != ESPERA);
        overrun_evt      = captura && valida_q && !muestra_lista;
        if (captura) begin
            muestra_d = paquete_bits;
            valida_d  = 1'b1;
        end else if (valida_q && muestra_lista) begin
            valida_d = 1'b0;
        end
        tick_perdido_d = tick_perdido_q;
        overrun_d      = overrun_q;
        if (borrar_flags) begin
            tick_perdido_d = 1'b0;
            overrun_d      = 1'b0;
        end
        if (tick_perdido_evt) begin
            tick_perdido_d = 1'b1;
        end
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end
`ifdef ADC_SCHED_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
        if (borrar_flags) begin
            timeout_err_d = 1'b0;
        end
        if (timeout_evt) begin
            timeout_err_d = 1'b1;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q       <= ESPERA;
            cnt_q          <= '0;
            per_q          <= '0;
            muestra_q      <= '0;
            valida_q       <= 1'b0;
            tick_perdido_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            cnt_q          <= cnt_d;
            per_q          <= per_d;
            muestra_q      <= muestra_d;
            valida_q       <= valida_d;
            tick_perdido_q <= tick_perdido_d;
            overrun_q      <= overrun_d;
        end
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    // Timeout counter and its sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // inicio_rx and ocupado decode straight from the state register.
    assign inicio_rx      = (estado_q == INICIO);
    assign ocupado        = (estado_q != ESPERA);
    assign muestra        = muestra_q;
    assign muestra_valida = valida_q;
    assign tick_perdido   = tick_perdido_q;
    assign overrun        = overrun_q;
    assign estado_dbg     = estado_q;

endmodule
